// File: rtl/spad_pulse_emulator.sv
// Synthetic SPAD avalanche source for closing the quench loop without a detector.
// Emits periodic or LFSR-driven pulses, follows quench/re-arm replies, and keeps
// saturating counts of emitted and self-terminated (missed) avalanches.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | disabled, pulse low
// S_ARMED    | waiting for a trigger, interval counter running
// S_AVALANCHE| pulse high, waiting for quench or hold timeout
// S_QUENCHED | dead time after quench, waiting for reset to re-arm
module spad_pulse_emulator #(
  parameter int          PULSE_MAX = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mode,
  input  logic [15:0] period,
  input  logic [15:0] threshold,
  input  logic        quench,
  input  logic        reset,
  input  logic        clear_stats,
  output logic        pulse,
  output logic        armed,
  output logic [31:0] pulse_cnt,
  output logic [15:0] miss_cnt
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED      = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          HW        = (PULSE_MAX > 1) ? $clog2(PULSE_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(PULSE_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_AVALANCHE,
    S_QUENCHED
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   icnt, icnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [31:0]   lfsr;
  logic [15:0]   period_m1;
  logic          fire;
  logic          emit;
  logic          miss;

  // Trigger decision for the current ARMED cycle; period 0 behaves as 1.
  always_comb begin
    period_m1 = (period == 16'd0) ? 16'd0 : (period - 16'd1);
    fire      = mode ? (lfsr[15:0] < threshold) : (icnt == period_m1);
  end

  // Next-state logic; en low overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    icnt_nxt  = icnt;
    hcnt_nxt  = hcnt;
    emit      = 1'b0;
    miss      = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_ARMED;
          icnt_nxt  = 16'd0;
        end
        S_ARMED: begin
          if (fire) begin
            state_nxt = S_AVALANCHE;
            hcnt_nxt  = '0;
            emit      = 1'b1;
          end else begin
            icnt_nxt = icnt + 16'd1;
          end
        end
        S_AVALANCHE: begin
          // Quench beats a coincident timeout, so such a pulse is not a miss.
          if (quench) begin
            state_nxt = S_QUENCHED;
          end else if (hcnt == HOLD_LAST) begin
            state_nxt = S_ARMED;
            icnt_nxt  = 16'd0;
            miss      = 1'b1;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        S_QUENCHED: begin
          if (reset) begin
            state_nxt = S_ARMED;
            icnt_nxt  = 16'd0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      icnt  <= 16'd0;
      hcnt  <= '0;
      pulse <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      icnt  <= icnt_nxt;
      hcnt  <= hcnt_nxt;
      pulse <= (state_nxt == S_AVALANCHE);
      armed <= (state_nxt == S_ARMED);
    end
  end

  // Galois LFSR, advances only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    end
  end

  // Saturating emitted-pulse counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= 32'd0;
    end else if (clear_stats) begin
      pulse_cnt <= 32'd0;
    end else if (emit && (pulse_cnt != 32'hFFFF_FFFF)) begin
      pulse_cnt <= pulse_cnt + 32'd1;
    end
  end

  // Saturating timeout counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= 16'd0;
    end else if (clear_stats) begin
      miss_cnt <= 16'd0;
    end else if (miss && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_spad_pulse_emulator.sv
// Bench for spad_pulse_emulator: scoreboard of expected pulse widths and
// armed gaps, plus a reference LFSR model for the random trigger mode.
module tb_spad_pulse_emulator;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [15:0] period;
  logic [15:0] threshold;
  logic        quench;
  logic        reset;
  logic        clear_stats;
  logic        pulse;
  logic        armed;
  logic [31:0] pulse_cnt;
  logic [15:0] miss_cnt;

  typedef struct {
    int width;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  bit   mon_on   = 1'b1;
  int   arm_run  = 0;
  int   cur_w    = 0;
  int   cur_gap  = 0;
  logic pulse_q  = 1'b0;
  int   ra, rb, base;

  spad_pulse_emulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .period      (period),
    .threshold   (threshold),
    .quench      (quench),
    .reset       (reset),
    .clear_stats (clear_stats),
    .pulse       (pulse),
    .armed       (armed),
    .pulse_cnt   (pulse_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_exp(input int w, input int g);
    exp_t e;
    e.width = w;
    e.gap   = g;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] x);
    logic [31:0] y;
    logic        b;
    b = x[0];
    y = x >> 1;
    y[31] = b;
    y[21] = y[21] ^ b;
    y[1]  = y[1] ^ b;
    y[0]  = y[0] ^ b;
    return y;
  endfunction

  task automatic wait_pulse(input int budget);
    int n = 0;
    @(negedge clk);
    while (!pulse && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_pulse", {31'd0, pulse}, 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_done", n_done, target);
  endtask

  // Monitor: measures each pulse width and the ARMED cycles preceding it.
  always @(negedge clk) begin
    exp_t e;
    if (!en) arm_run = 0;
    if (pulse) begin
      if (!pulse_q) begin
        cur_gap = arm_run;
        cur_w   = 0;
      end
      cur_w++;
    end else if (pulse_q && mon_on) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("sb_width", cur_w, e.width);
        check_val("sb_gap", cur_gap, e.gap);
      end
      n_done++;
    end
    if (pulse_q && !pulse) arm_run = 0;
    if (armed) arm_run++;
    pulse_q = pulse;
  end

  task automatic rnd_run(input logic [15:0] thr, input int ncyc, output int rises);
    int          exp_q[$];
    logic [31:0] m_lfsr;
    int          st;
    int          hold;
    int          n_exp;
    logic        pq;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b1;
    threshold = thr;
    quench = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rnd_reset_cnt", pulse_cnt, 32'd0);
    m_lfsr = 32'hACE1_1234;
    st = 0;
    hold = 0;
    for (int c = 1; c <= ncyc; c++) begin
      case (st)
        0: st = 1;
        1: if (m_lfsr[15:0] < thr) begin
             st = 2;
             hold = 0;
             exp_q.push_back(c);
           end
        default: if (hold == 15) st = 1; else hold++;
      endcase
      m_lfsr = lfsr_model(m_lfsr);
    end
    n_exp = exp_q.size();
    en = 1'b1;
    pq = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (pulse && !pq) begin
        if (exp_q.size() == 0) check_val("rnd_extra_rise", c, 32'd0);
        else check_val("rnd_rise_cyc", c, exp_q.pop_front());
      end
      pq = pulse;
    end
    check_val("rnd_missing", exp_q.size(), 32'd0);
    check_val("rnd_pulse_cnt", pulse_cnt, n_exp);
    rises = int'(pulse_cnt);
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    period = 16'd10;
    threshold = 16'd0;
    quench = 1'b0;
    reset = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pulse", {31'd0, pulse}, 32'd0);
    check_val("rst_armed", {31'd0, armed}, 32'd0);
    check_val("rst_pulse_cnt", pulse_cnt, 32'd0);
    check_val("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: periodic, quench after 3 high cycles, re-arm 4 cycles later
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_exp(4, 10);
      wait_pulse(40);
      repeat (3) @(negedge clk);
      quench = 1'b1;
      @(negedge clk);
      quench = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_val("t1_pulse_cnt", pulse_cnt, 32'd100);
    check_val("t1_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    check_val("t1_sb_empty", sb_q.size(), 32'd0);

    // T2: no quench, pulses self-terminate after 16 cycles
    en = 1'b0;
    repeat (2) @(negedge clk);
    period = 16'd5;
    base = n_done;
    for (int i = 0; i < 5; i++) push_exp(16, 5);
    en = 1'b1;
    wait_done(base + 5, 150);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t2_miss_cnt", {16'd0, miss_cnt}, 32'd5);
    check_val("t2_pulse_cnt", pulse_cnt, 32'd105);

    // T3: quench and reset together on the 2nd high cycle
    push_exp(2, 5);
    en = 1'b1;
    wait_pulse(30);
    @(negedge clk);
    quench = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    quench = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("t3_quenched_pulse", {31'd0, pulse}, 32'd0);
    check_val("t3_quenched_armed", {31'd0, armed}, 32'd0);
    check_val("t3_pulse_cnt", pulse_cnt, 32'd106);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("t3_rearmed", {31'd0, armed}, 32'd1);

    // T5: abort by dropping en mid-pulse, then restart with period 3
    push_exp(2, 5);
    wait_pulse(30);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_val("t5_abort_pulse", {31'd0, pulse}, 32'd0);
    check_val("t5_abort_armed", {31'd0, armed}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("t5_pulse_cnt", pulse_cnt, 32'd107);
    check_val("t5_miss_cnt", {16'd0, miss_cnt}, 32'd5);
    period = 16'd3;
    push_exp(1, 3);
    en = 1'b1;
    wait_pulse(20);
    quench = 1'b1;
    @(negedge clk);
    quench = 1'b0;
    check_val("t5_min_width", {31'd0, pulse}, 32'd0);
    check_val("t5_pulse_cnt2", pulse_cnt, 32'd108);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // T6: miss counter saturation, then clear coincident with a trigger
    force dut.miss_cnt = 16'hFFFE;
    #1;
    release dut.miss_cnt;
    @(negedge clk);
    check_val("t6_preload", {16'd0, miss_cnt}, 32'h0000_FFFE);
    period = 16'd2;
    base = n_done;
    for (int i = 0; i < 3; i++) push_exp(16, 2);
    en = 1'b1;
    wait_done(base + 3, 100);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t6_miss_sat", {16'd0, miss_cnt}, 32'h0000_FFFF);
    check_val("t6_pulse_cnt", pulse_cnt, 32'd111);
    period = 16'd4;
    push_exp(1, 4);
    en = 1'b1;
    repeat (4) @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check_val("t6_trig_timing", {31'd0, pulse}, 32'd1);
    check_val("t6_clear_pulse_cnt", pulse_cnt, 32'd0);
    check_val("t6_clear_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    quench = 1'b1;
    @(negedge clk);
    quench = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t6_after_clear", pulse_cnt, 32'd0);
    check_val("sb_drained", sb_q.size(), 32'd0);

    // Async reset in the middle of a pulse
    mon_on = 1'b0;
    mode = 1'b0;
    period = 16'd2;
    en = 1'b1;
    wait_pulse(20);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_pulse", {31'd0, pulse}, 32'd0);
    check_val("arst_armed", {31'd0, armed}, 32'd0);
    check_val("arst_pulse_cnt", pulse_cnt, 32'd0);

    // T4: random mode against the reference LFSR
    rnd_run(16'h0000, 10000, ra);
    check_val("t4_never", ra, 32'd0);
    rnd_run(16'h8000, 2000, ra);
    rnd_run(16'h8000, 2000, rb);
    check_val("t4_repeat", rb, ra);
    check_val("t4_density", {31'd0, (ra >= 60 && ra <= 140)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
